// File: rtl/mux2_pkg.sv
// Shared constants and helpers for the 2-to-1 stream multiplexer.
package mux2_pkg;

   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

   localparam int unsigned DW_DEFAULT = 8;
   localparam int unsigned CNT_W      = 4;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_MAX = '1;

   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == CNT_MAX) ? c : c + cnt_t'(1);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with bounded bursts; grants are qualified by output space.
module rr_arb2
   import mux2_pkg::*;
#(
   parameter int unsigned BURST = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic v0,
   input  logic v1,
   input  logic space,
   input  logic xfer,
   output logic g0,
   output logic g1
);

   // Under contention the last winner keeps the grant while cnt < HOLD.
   localparam cnt_t HOLD = cnt_t'(BURST - 1);

   logic last_q;
   cnt_t cnt_q;
   logic pick;

   always_comb begin
      if (v0 && v1) begin
         pick = (cnt_q < HOLD) ? last_q : ~last_q;
      end else begin
         pick = v1;
      end
      g0 = v0 && (pick == SRC0) && space;
      g1 = v1 && (pick == SRC1) && space;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= SRC1;
         cnt_q  <= '0;
      end else if (xfer) begin
         if (pick == last_q) begin
            cnt_q <= sat_inc(cnt_q);
         end else begin
            last_q <= pick;
            cnt_q  <= '0;
         end
      end
   end

endmodule

// File: rtl/mux2_stream.sv
// Round-robin 2-to-1 valid/ready merge into a one-entry registered output tagged with source id.
module mux2_stream
   import mux2_pkg::*;
#(
   parameter int unsigned DW    = DW_DEFAULT,
   parameter int unsigned BURST = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] d0,
   input  logic          v0,
   output logic          r0,
   input  logic [DW-1:0] d1,
   input  logic          v1,
   output logic          r1,
   output logic [DW-1:0] z,
   output logic          zv,
   output logic          zs,
   input  logic          zr
);

   logic space;
   logic g0;
   logic g1;
   logic xfer;

   // The register can take a new word when empty or when its word leaves this cycle.
   assign space = !zv || zr;
   assign r0    = g0 && !rst;
   assign r1    = g1 && !rst;
   assign xfer  = r0 || r1;

   rr_arb2 #(
      .BURST (BURST)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .v0    (v0),
      .v1    (v1),
      .space (space),
      .xfer  (xfer),
      .g0    (g0),
      .g1    (g1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z  <= '0;
         zv <= 1'b0;
         zs <= SRC0;
      end else if (xfer) begin
         z  <= r1 ? d1 : d0;
         zs <= r1 ? SRC1 : SRC0;
         zv <= 1'b1;
      end else if (zr) begin
         zv <= 1'b0;
      end
   end

endmodule
